// File: rtl/vc_fifo_pkg.sv
// vc_fifo_pkg: shared width helpers and error-cause codes for the virtual-channel FIFO
package vc_fifo_pkg;
  typedef enum logic [1:0] {ERR_NONE, ERR_FULL, ERR_EMPTY, ERR_VC} err_cause_e;
  function automatic int vcw_f(input int num_vc);
    return num_vc > 1 ? $clog2(num_vc) : 1;
  endfunction
  function automatic int ocup_w_f(input int addrsize);
    return addrsize + 1;
  endfunction
endpackage

// File: rtl/vc_fifo_if.sv
// vc_fifo_if: request, data and per-channel status bundle of vc_fifo
interface vc_fifo_if #(
  parameter int DSIZE = 32,
  parameter int ADDRSIZE = 4,
  parameter int NUM_VC = 4
);
  import vc_fifo_pkg::*;
  localparam int VCW = vcw_f(NUM_VC);
  localparam int OW = ocup_w_f(ADDRSIZE);
  logic write_en;
  logic [VCW-1:0] write_vc;
  logic [DSIZE-1:0] data_in;
  logic read_en;
  logic [VCW-1:0] read_vc;
  logic [DSIZE-1:0] data_out;
  logic data_valid;
  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] empty;
  logic [NUM_VC-1:0] almost_full;
  logic [NUM_VC*OW-1:0] ocup;
  logic error;
  modport master (
    output write_en, write_vc, data_in, read_en, read_vc,
    input data_out, data_valid, full, empty, almost_full, ocup, error
  );
  modport slave (
    input write_en, write_vc, data_in, read_en, read_vc,
    output data_out, data_valid, full, empty, almost_full, ocup, error
  );
endinterface

// File: rtl/vc_fifo_ctrl.sv
// vc_fifo_ctrl: one channel's wrapping pointers, occupancy and registered status flags
module vc_fifo_ctrl #(
  parameter int ADDRSIZE = 4,
  parameter int AF_LEVEL = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic wr,
  input  logic rd,
  output logic [ADDRSIZE:0] wptr,
  output logic [ADDRSIZE:0] rptr,
  output logic [ADDRSIZE:0] ocup,
  output logic full,
  output logic empty,
  output logic almost_full
);
  localparam logic [ADDRSIZE:0] DEPTH_O = {1'b1, {ADDRSIZE{1'b0}}};
  localparam logic [ADDRSIZE:0] AF_O = AF_LEVEL[ADDRSIZE:0];
  logic [ADDRSIZE:0] wptr_n, rptr_n, ocup_n;
  always_comb begin
    wptr_n = wptr + {{ADDRSIZE{1'b0}}, wr};
    rptr_n = rptr + {{ADDRSIZE{1'b0}}, rd};
    ocup_n = wptr_n - rptr_n;
  end
  // flags come from the next occupancy so they are registered yet current
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      ocup <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      ocup <= ocup_n;
      full <= ocup_n == DEPTH_O;
      empty <= ocup_n == '0;
      almost_full <= ocup_n >= AF_O;
    end
endmodule

// File: rtl/vc_fifo.sv
// vc_fifo: NUM_VC independent FIFOs over one shared word array indexed {vc, ptr}
// Define VC_FIFO_FWFT_EN for a first-word-fall-through read port; default is a registered read port.
module vc_fifo
  import vc_fifo_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int ADDRSIZE = 4,
  parameter int NUM_VC = 4,
  parameter int AF_LEVEL = (1 << ADDRSIZE) - 2
) (
  input logic clk,
  input logic reset,
  vc_fifo_if.slave bus
);
  localparam int VCW = vcw_f(NUM_VC);
  localparam int OW = ocup_w_f(ADDRSIZE);
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [VCW:0] NVC = NUM_VC[VCW:0];
  logic [DSIZE-1:0] mem [NUM_VC*DEPTH];
  logic [ADDRSIZE:0] wptr [NUM_VC];
  logic [ADDRSIZE:0] rptr [NUM_VC];
  logic [NUM_VC-1:0] wr, rd, full, empty, almost_full;
  logic [NUM_VC*OW-1:0] ocup;
  logic wvc_ok, rvc_ok, wr_acc, rd_acc;
  logic [ADDRSIZE:0] wp, rp;
  logic [DSIZE-1:0] head;
  // a full channel still takes a write when the same edge pops it
  always_comb begin
    wvc_ok = {1'b0, bus.write_vc} < NVC;
    rvc_ok = {1'b0, bus.read_vc} < NVC;
    wp = wptr[bus.write_vc];
    rp = rptr[bus.read_vc];
    rd_acc = bus.read_en && rvc_ok && !empty[bus.read_vc];
    wr_acc = bus.write_en && wvc_ok &&
             (!full[bus.write_vc] || (rd_acc && bus.read_vc == bus.write_vc));
    head = mem[{bus.read_vc, rp[ADDRSIZE-1:0]}];
  end
  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    assign wr[i] = wr_acc && bus.write_vc == VCW'(i);
    assign rd[i] = rd_acc && bus.read_vc == VCW'(i);
    vc_fifo_ctrl #(
      .ADDRSIZE(ADDRSIZE),
      .AF_LEVEL(AF_LEVEL)
    ) u_ctrl (
      .clk(clk),
      .reset(reset),
      .wr(wr[i]),
      .rd(rd[i]),
      .wptr(wptr[i]),
      .rptr(rptr[i]),
      .ocup(ocup[i*OW +: OW]),
      .full(full[i]),
      .empty(empty[i]),
      .almost_full(almost_full[i])
    );
  end
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.almost_full = almost_full;
  assign bus.ocup = ocup;
  always_ff @(posedge clk)
    if (wr_acc) mem[{bus.write_vc, wp[ADDRSIZE-1:0]}] <= bus.data_in;
  always_ff @(posedge clk or negedge reset)
    if (!reset) bus.error <= 1'b0;
    else bus.error <= (bus.write_en && !wr_acc) || (bus.read_en && !rd_acc);
`ifdef VC_FIFO_FWFT_EN
  logic dv;
  assign dv = rvc_ok && !empty[bus.read_vc];
  assign bus.data_valid = dv;
  assign bus.data_out = dv ? head : '0;
`else
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.data_out <= '0;
      bus.data_valid <= 1'b0;
    end else begin
      bus.data_valid <= rd_acc;
      if (rd_acc) bus.data_out <= head;
    end
`endif
endmodule

// File: tb/tb_vc_fifo.sv
// tb_vc_fifo: randomized and directed check of vc_fifo against per-channel queue model
module tb_vc_fifo;
  import vc_fifo_pkg::*;
  localparam int DSIZE = 32;
  localparam int ADDRSIZE = 4;
  localparam int NUM_VC = 4;
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam int AF_LEVEL = DEPTH - 2;
  localparam int OW = ocup_w_f(ADDRSIZE);
  localparam int VCW = vcw_f(NUM_VC);
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic chk_en = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [DSIZE-1:0] q [NUM_VC][$];
  logic [DSIZE-1:0] exp_dout = '0;
  logic [DSIZE-1:0] last_pop = '0;
  logic exp_dv = 1'b0;
  logic exp_err = 1'b0;
  logic rok, wok;
  err_cause_e cause;
  int err_cnt [4] = '{0, 0, 0, 0};
  int m_wv, m_rv, c_rv, err_before;
  vc_fifo_if #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE), .NUM_VC(NUM_VC)) bif ();
  vc_fifo #(
    .DSIZE(DSIZE),
    .ADDRSIZE(ADDRSIZE),
    .NUM_VC(NUM_VC),
    .AF_LEVEL(AF_LEVEL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic we, input int wvc, input logic [DSIZE-1:0] din,
                      input logic re, input int rvc);
    @(negedge clk);
    #1;
    bif.write_en = we;
    bif.write_vc = VCW'(wvc);
    bif.data_in = din;
    bif.read_en = re;
    bif.read_vc = VCW'(rvc);
  endtask
  task automatic idle();
    step(1'b0, 0, '0, 1'b0, 0);
  endtask
  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask
  function automatic int err_total();
    return err_cnt[1] + err_cnt[2] + err_cnt[3];
  endfunction
  // reference model: one queue per channel, updated from the driven requests
  always @(posedge clk) if (reset) begin
    m_wv = int'(bif.write_vc);
    m_rv = int'(bif.read_vc);
    rok = bif.read_en && m_rv < NUM_VC && q[m_rv].size() > 0;
    wok = bif.write_en && m_wv < NUM_VC && (q[m_wv].size() < DEPTH || (rok && m_rv == m_wv));
    cause = (bif.read_en && !rok) ? (m_rv >= NUM_VC ? ERR_VC : ERR_EMPTY) :
            (bif.write_en && !wok) ? (m_wv >= NUM_VC ? ERR_VC : ERR_FULL) : ERR_NONE;
    exp_err = cause != ERR_NONE;
    if (exp_err) err_cnt[cause]++;
    exp_dv = rok;
    if (rok) begin
      last_pop = q[m_rv].pop_front();
      exp_dout = last_pop;
    end
    if (wok) q[m_wv].push_back(bif.data_in);
  end
  always @(negedge clk) if (chk_en) begin
    for (int v = 0; v < NUM_VC; v++) begin
      chk($sformatf("ocup[%0d]", v), bif.ocup[v*OW +: OW], q[v].size());
      chk($sformatf("full[%0d]", v), bif.full[v], q[v].size() == DEPTH);
      chk($sformatf("empty[%0d]", v), bif.empty[v], q[v].size() == 0);
      chk($sformatf("almost_full[%0d]", v), bif.almost_full[v], q[v].size() >= AF_LEVEL);
    end
    chk("error", bif.error, exp_err);
`ifdef VC_FIFO_FWFT_EN
    c_rv = int'(bif.read_vc);
    chk("data_valid", bif.data_valid, q[c_rv].size() > 0);
    chk("data_out", bif.data_out, q[c_rv].size() > 0 ? q[c_rv][0] : '0);
`else
    chk("data_valid", bif.data_valid, exp_dv);
    chk("data_out", bif.data_out, exp_dout);
`endif
  end
  task automatic reset_checks(input string tag);
    chk({tag, "_ocup"}, bif.ocup, '0);
    chk({tag, "_empty"}, bif.empty, {NUM_VC{1'b1}});
    chk({tag, "_full"}, bif.full, '0);
    chk({tag, "_af"}, bif.almost_full, '0);
    chk({tag, "_error"}, bif.error, 1'b0);
    chk({tag, "_dv"}, bif.data_valid, 1'b0);
    chk({tag, "_dout"}, bif.data_out, '0);
  endtask
  initial begin
    bif.write_en = 1'b0;
    bif.write_vc = '0;
    bif.data_in = '0;
    bif.read_en = 1'b0;
    bif.read_vc = '0;
    repeat (2) @(negedge clk);
    reset_checks("rst");
    #1;
    reset = 1'b1;
    chk_en = 1'b1;
    // basic writes to two channels and ordered reads of one
    step(1'b1, 0, 32'h0101A5A5, 1'b0, 0);
    step(1'b1, 0, 32'h0000BBBB, 1'b0, 0);
    step(1'b1, 2, 32'h00010001, 1'b0, 0);
    wait_edge();
    chk("ocup0_two", bif.ocup[0*OW +: OW], 2);
    chk("ocup2_one", bif.ocup[2*OW +: OW], 1);
    chk("model_q0_two", q[0].size(), 2);
    step(1'b0, 0, '0, 1'b1, 0);
`ifdef VC_FIFO_FWFT_EN
    #1 chk("fwft_first", bif.data_out, 32'h0101A5A5);
`endif
    wait_edge();
`ifndef VC_FIFO_FWFT_EN
    chk("reg_first", bif.data_out, 32'h0101A5A5);
    chk("reg_first_dv", bif.data_valid, 1'b1);
`endif
    step(1'b0, 0, '0, 1'b1, 0);
`ifdef VC_FIFO_FWFT_EN
    #1 chk("fwft_second", bif.data_out, 32'h0000BBBB);
`endif
    wait_edge();
`ifndef VC_FIFO_FWFT_EN
    chk("reg_second", bif.data_out, 32'h0000BBBB);
`endif
    // fill VC1, then overflow it
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1, 32'h1000 + i, 1'b0, 0);
    wait_edge();
    chk("full1", bif.full[1], 1'b1);
    chk("af1", bif.almost_full[1], 1'b1);
    chk("model_q1_full", q[1].size(), DEPTH);
    step(1'b1, 1, 32'hDEADBEEF, 1'b0, 0);
    wait_edge();
    chk("ovf_error", bif.error, 1'b1);
    chk("ovf_ocup1", bif.ocup[1*OW +: OW], DEPTH);
    chk("model_err_full", err_cnt[ERR_FULL], 1);
    idle();
    wait_edge();
    chk("ovf_error_gone", bif.error, 1'b0);
    // read+write on a full channel, new word must come out last
    step(1'b1, 1, 32'h0100CCCC, 1'b1, 1);
    wait_edge();
    chk("rw_full_ocup1", bif.ocup[1*OW +: OW], DEPTH);
    chk("rw_full_error", bif.error, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 0, '0, 1'b1, 1);
    idle();
    wait_edge();
    chk("model_last_pop", last_pop, 32'h0100CCCC);
    chk("drained_empty1", bif.empty[1], 1'b1);
`ifndef VC_FIFO_FWFT_EN
    chk("reg_last_word", bif.data_out, 32'h0100CCCC);
`endif
    // read of empty VC3 is illegal even with a same-cycle write
    step(1'b1, 3, 32'h00003333, 1'b1, 3);
    wait_edge();
    chk("empty_rd_error", bif.error, 1'b1);
    chk("empty_rd_ocup3", bif.ocup[3*OW +: OW], 1);
    chk("model_err_empty", err_cnt[ERR_EMPTY], 1);
    step(1'b0, 0, '0, 1'b1, 3);
    // stream through VC0 to force several pointer wraps
    err_before = err_total();
    for (int i = 0; i < 3 * DEPTH; i++) step(1'b1, 0, 32'h5000 + i, q[0].size() >= 3, 0);
    for (int i = 0; i < DEPTH && q[0].size() > 0; i++) step(1'b0, 0, '0, q[0].size() > 1, 0);
    idle();
    wait_edge();
    chk("stream_no_err", err_total(), err_before);
    chk("stream_last", last_pop, 32'h5000 + 3 * DEPTH - 1);
    // random traffic on all channels
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 50, $urandom_range(0, NUM_VC - 1), $urandom,
           $urandom_range(0, 99) < 55, $urandom_range(0, NUM_VC - 1));
    for (int i = 0; i < DEPTH && q[0].size() > 0; i++) step(1'b0, 0, '0, 1'b1, 0);
    // asynchronous reset with VC0 holding five words
    for (int i = 0; i < 5; i++) step(1'b1, 0, 32'h7700 + i, 1'b0, 0);
    idle();
    wait_edge();
    chk("pre_rst_ocup0", bif.ocup[0*OW +: OW], 5);
    #1;
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    reset_checks("async_rst");
    for (int v = 0; v < NUM_VC; v++) q[v].delete();
    exp_err = 1'b0;
    exp_dv = 1'b0;
    exp_dout = '0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    chk_en = 1'b1;
    step(1'b1, 0, 32'h0000ABCD, 1'b0, 0);
    step(1'b0, 0, '0, 1'b1, 0);
    idle();
    wait_edge();
    chk("post_rst_word", last_pop, 32'h0000ABCD);
    repeat (2) idle();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
